// File: rtl/stage_sequencer.sv
// stage_sequencer: multi-cycle CPU stage controller.
// Steps FET->DEC->EXE->MEM->WBK, stalls MEM, halts on ecall or MEM timeout.
//
// Ports:
//   sysclk, cpu_reset          clock, synchronous active-high reset
//   run                        permits leaving FET
//   mem_req_needed, mem_ready  MEM-stage access request / acknowledge
//   halt_req                   EXE instruction is ecall/ebreak
//   stage                      one-hot stage (0 when halted)
//   fet_en..wbk_en             per-stage register load strobes
//   mem_strobe                 memory access request level
//   halted, timeout_err        parked in HALT / HALT caused by MEM timeout
//   retired                    completed instruction count
module stage_sequencer #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             sysclk,
    input  logic             cpu_reset,
    input  logic             run,
    input  logic             mem_req_needed,
    input  logic             mem_ready,
    input  logic             halt_req,
    output logic [4:0]       stage,
    output logic             fet_en,
    output logic             dec_en,
    output logic             exe_en,
    output logic             mem_en,
    output logic             wbk_en,
    output logic             mem_strobe,
    output logic             halted,
    output logic             timeout_err,
    output logic [CNT_W-1:0] retired
);

    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    // Wait count seen on the last permitted stalled MEM cycle.
    localparam logic [WW-1:0] LAST = WW'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FET,
        S_DEC,
        S_EXE,
        S_MEM,
        S_WBK,
        S_HALT
    } state_t;

    state_t        state;
    state_t        nxt;
    logic [WW-1:0] wait_cnt;
    logic          halt_pending;
    logic          timeout_hit;

    function automatic logic [4:0] onehot(input state_t s);
        logic [4:0] v;
        v = 5'b0;
        unique case (s)
            S_FET:   v = 5'b00001;
            S_DEC:   v = 5'b00010;
            S_EXE:   v = 5'b00100;
            S_MEM:   v = 5'b01000;
            S_WBK:   v = 5'b10000;
            default: v = 5'b00000;
        endcase
        return v;
    endfunction

    always_comb begin
        nxt         = state;
        fet_en      = 1'b0;
        dec_en      = 1'b0;
        exe_en      = 1'b0;
        mem_en      = 1'b0;
        wbk_en      = 1'b0;
        mem_strobe  = 1'b0;
        timeout_hit = 1'b0;
        unique case (state)
            S_FET: begin
                if (run) begin
                    fet_en = 1'b1;
                    nxt    = S_DEC;
                end
            end
            S_DEC: begin
                dec_en = 1'b1;
                nxt    = S_EXE;
            end
            S_EXE: begin
                exe_en = 1'b1;
                nxt    = S_MEM;
            end
            S_MEM: begin
                if (!mem_req_needed) begin
                    mem_en = 1'b1;
                    nxt    = S_WBK;
                end else begin
                    mem_strobe = 1'b1;
                    if (mem_ready) begin
                        mem_en = 1'b1;
                        nxt    = S_WBK;
                    end else if (wait_cnt == LAST) begin
                        // Access abandoned: instruction never writes back.
                        timeout_hit = 1'b1;
                        nxt         = S_HALT;
                    end
                end
            end
            S_WBK: begin
                wbk_en = 1'b1;
                nxt    = halt_pending ? S_HALT : S_FET;
            end
            S_HALT: nxt = S_HALT;
            default: nxt = S_HALT;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (cpu_reset) begin
            state        <= S_FET;
            stage        <= 5'b00001;
            halted       <= 1'b0;
            timeout_err  <= 1'b0;
            retired      <= '0;
            wait_cnt     <= '0;
            halt_pending <= 1'b0;
        end else begin
            state  <= nxt;
            stage  <= onehot(nxt);
            halted <= (nxt == S_HALT);
            if (timeout_hit)
                timeout_err <= 1'b1;
            if (exe_en && halt_req)
                halt_pending <= 1'b1;
            if (wbk_en)
                retired <= retired + CNT_W'(1);
            if (state == S_MEM && nxt == S_MEM)
                wait_cnt <= wait_cnt + WW'(1);
            else
                wait_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer: directed + random check of stage_sequencer
// against a phase-index reference model.
module tb_stage_sequencer;

    localparam int TMO = 4;
    localparam int CW  = 8;

    logic          sysclk = 1'b0;
    logic          rst;
    logic          run;
    logic          req;
    logic          rdy;
    logic          hreq;
    logic [4:0]    stage;
    logic          fet_en;
    logic          dec_en;
    logic          exe_en;
    logic          mem_en;
    logic          wbk_en;
    logic          mem_strobe;
    logic          halted;
    logic          timeout_err;
    logic [CW-1:0] retired;

    always #5 sysclk = ~sysclk;

    stage_sequencer #(
        .MEM_TIMEOUT(TMO),
        .CNT_W      (CW)
    ) dut (
        .sysclk        (sysclk),
        .cpu_reset     (rst),
        .run           (run),
        .mem_req_needed(req),
        .mem_ready     (rdy),
        .halt_req      (hreq),
        .stage         (stage),
        .fet_en        (fet_en),
        .dec_en        (dec_en),
        .exe_en        (exe_en),
        .mem_en        (mem_en),
        .wbk_en        (wbk_en),
        .mem_strobe    (mem_strobe),
        .halted        (halted),
        .timeout_err   (timeout_err),
        .retired       (retired)
    );

    int n_chk;
    int n_fail;

    // Model: ph = 0..4 pipeline phase, 5 = halted.
    int ph;
    int mw;
    int mret;
    bit mterr;
    bit mhp;

    logic [4:0] s_en;
    logic       s_strobe;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        ph    = 0;
        mw    = 0;
        mret  = 0;
        mterr = 1'b0;
        mhp   = 1'b0;
    endtask

    // One clock: check outputs against model mid-cycle, then step model.
    task automatic tick();
        bit         adv;
        bit         tmo;
        logic [4:0] e_en;
        logic [4:0] e_stage;
        logic [4:0] o_en;
        int         nph;
        @(negedge sysclk);
        adv = (ph == 0 && run) || ph == 1 || ph == 2 || ph == 4 ||
              (ph == 3 && (!req || rdy));
        tmo = (ph == 3) && req && !rdy && (mw + 1 >= TMO);
        e_stage = (ph < 5) ? 5'(1 << ph) : 5'b0;
        e_en    = adv ? 5'(1 << ph) : 5'b0;
        o_en    = {wbk_en, mem_en, exe_en, dec_en, fet_en};
        chk("stage", 64'(stage), 64'(e_stage));
        chk("strobes", 64'(o_en), 64'(e_en));
        chk("mem_strobe", 64'(mem_strobe), 64'(ph == 3 && req));
        chk("halted", 64'(halted), 64'(ph == 5));
        chk("timeout_err", 64'(timeout_err), 64'(mterr));
        chk("retired", 64'(retired), 64'(mret));
        s_en     = o_en;
        s_strobe = mem_strobe;
        @(posedge sysclk);
        if (rst) begin
            model_reset();
        end else begin
            nph = ph;
            if (ph == 2 && hreq)
                mhp = 1'b1;
            if (ph == 3) begin
                if (adv || tmo)
                    mw = 0;
                else
                    mw++;
            end
            if (tmo) begin
                mterr = 1'b1;
                nph   = 5;
            end else if (adv) begin
                if (ph == 4) begin
                    mret = (mret + 1) % (1 << CW);
                    nph  = mhp ? 5 : 0;
                end else begin
                    nph = ph + 1;
                end
            end
            ph = nph;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    int cnt_a;
    int cnt_b;

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        run    = 1'b0;
        req    = 1'b0;
        rdy    = 1'b0;
        hreq   = 1'b0;
        model_reset();
        @(posedge sysclk);
        #1;
        rst = 1'b0;
        chk("rst_stage", 64'(stage), 64'd1);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_terr", 64'(timeout_err), 64'd0);
        chk("rst_retired", 64'(retired), 64'd0);

        // Free run, no memory access.
        run = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("t1_retired", 64'(retired), 64'd4);
        chk("t1_stage", 64'(stage), 64'd1);

        // Three MEM wait cycles then ready.
        req   = 1'b1;
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < 8; i++) begin
            rdy = (i == 6);
            tick();
            cnt_a += int'(s_strobe);
            cnt_b += int'(s_en[3]);
        end
        chk("t2_strobe_cycles", 64'(cnt_a), 64'd4);
        chk("t2_mem_en_pulses", 64'(cnt_b), 64'd1);
        chk("t2_back_to_fet", 64'(stage), 64'd1);
        chk("t2_retired", 64'(retired), 64'd5);

        // Memory never ready: timeout halt.
        rdy = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("t3_halted", 64'(halted), 64'd1);
        chk("t3_terr", 64'(timeout_err), 64'd1);
        chk("t3_stage", 64'(stage), 64'd0);
        chk("t3_retired", 64'(retired), 64'd5);
        for (int i = 0; i < 10; i++) tick();
        chk("t3_still_halted", 64'(halted), 64'd1);
        chk("t3_still_retired", 64'(retired), 64'd5);

        // ecall in EXE: finish instruction, then halt.
        do_reset();
        req = 1'b0;
        tick();
        tick();
        hreq = 1'b1;
        tick();
        hreq = 1'b0;
        tick();
        tick();
        chk("t4_halted", 64'(halted), 64'd1);
        chk("t4_retired", 64'(retired), 64'd1);
        chk("t4_terr", 64'(timeout_err), 64'd0);
        cnt_a = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            cnt_a += int'(s_en != 5'b0) + int'(s_strobe);
        end
        chk("t4_no_strobes", 64'(cnt_a), 64'd0);
        do_reset();
        chk("t4_reset_stage", 64'(stage), 64'd1);
        chk("t4_reset_halted", 64'(halted), 64'd0);

        // run held low at FET.
        run   = 1'b0;
        cnt_a = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            cnt_a += int'(s_en[0]);
        end
        chk("t5_fet_en_low", 64'(cnt_a), 64'd0);
        chk("t5_stage", 64'(stage), 64'd1);
        run = 1'b1;
        tick();
        chk("t5_fet_en", 64'(s_en[0]), 64'd1);
        chk("t5_dec", 64'(stage), 64'd2);

        // Reset during MEM wait clears the wait counter.
        req = 1'b1;
        rdy = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        do_reset();
        chk("t6_stage", 64'(stage), 64'd1);
        chk("t6_retired", 64'(retired), 64'd0);
        chk("t6_terr", 64'(timeout_err), 64'd0);
        for (int i = 0; i < 3; i++) tick();
        tick();
        tick();
        tick();
        rdy = 1'b1;
        tick();
        tick();
        chk("t6_no_timeout", 64'(timeout_err), 64'd0);
        chk("t6_retired_after", 64'(retired), 64'd1);

        // Counter wrap: 260 instructions -> 4 mod 256.
        do_reset();
        req = 1'b0;
        rdy = 1'b0;
        for (int i = 0; i < 1300; i++) tick();
        chk("wrap_retired", 64'(retired), 64'd4);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            rst  = ($urandom_range(0, 299) == 0) ||
                   (ph == 5 && $urandom_range(0, 5) == 0);
            run  = ($urandom_range(0, 9) != 0);
            req  = $urandom_range(0, 1) == 1;
            rdy  = ($urandom_range(0, 2) == 0);
            hreq = ($urandom_range(0, 24) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
